instr_fetch_unit: RTL and testbench

Fetch front end that feeds the control unit. Issues word-addressed reads to instruction memory over a request/grant plus response-valid handshake and buffers returned instructions in a 2-entry FIFO. Presents the head instruction, its PC and its 3-bit opCode field to decode under a valid/ready handshake. A branch redirect from execute flushes the buffer and discards any in-flight response.

---
 rtl/instr_fetch_unit.sv | 144 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: one-outstanding word read port to instruction memory
// feeding a 2-entry {instr, pc} FIFO that decode drains under valid/ready.
module instr_fetch_unit #(
  parameter int                INSTR_W  = 16,
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [2:0]         opCode,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t             r_state;
  state_t             w_state_nxt;
  logic [ADDR_W-1:0]  r_fetch_pc;
  logic [ADDR_W-1:0]  r_pc_inflight;
  logic [INSTR_W-1:0] r_instr [0:1];
  logic [ADDR_W-1:0]  r_pc    [0:1];
  logic [1:0]         r_count;
  logic               w_accept;
  logic               w_push;
  logic               w_pop;

  // Request is decoded from state and occupancy only; rst masks it asynchronously.
  assign imem_req    = (r_state == S_REQ) && (r_count < 2'd2) && !rst;
  assign imem_addr   = r_fetch_pc;
  assign w_accept    = imem_req && imem_gnt;
  assign w_push      = (r_state == S_WAIT) && imem_rvalid && !redirect_valid;
  assign w_pop       = instr_valid && instr_ready && !redirect_valid;
  assign instr_valid = (r_count != 2'd0);
  assign instr       = r_instr[0];
  assign opCode      = r_instr[0][INSTR_W-1 -: 3];
  assign instr_pc    = r_pc[0];

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_REQ: begin
        if (w_accept) begin
          w_state_nxt = redirect_valid ? S_DROP : S_WAIT;
        end else begin
          w_state_nxt = S_REQ;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          w_state_nxt = S_REQ;
        end else if (redirect_valid) begin
          w_state_nxt = S_DROP;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_DROP: begin
        if (imem_rvalid) begin
          w_state_nxt = S_REQ;
        end else begin
          w_state_nxt = S_DROP;
        end
      end
      default: begin
        w_state_nxt = S_REQ;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_REQ;
      r_fetch_pc    <= RESET_PC;
      r_pc_inflight <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      if (redirect_valid) begin
        r_fetch_pc <= redirect_pc;
      end else if (w_accept) begin
        r_fetch_pc <= r_fetch_pc + PC_ONE;
      end
      if (w_accept) begin
        r_pc_inflight <= r_fetch_pc;
      end
    end
  end

  // Entry 0 is always the head; a pop shifts entry 1 down.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count    <= 2'd0;
      r_instr[0] <= {INSTR_W{1'b0}};
      r_instr[1] <= {INSTR_W{1'b0}};
      r_pc[0]    <= {ADDR_W{1'b0}};
      r_pc[1]    <= {ADDR_W{1'b0}};
    end else if (redirect_valid) begin
      r_count <= 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          r_instr[r_count[0]] <= imem_rdata;
          r_pc[r_count[0]]    <= r_pc_inflight;
          r_count             <= r_count + 2'd1;
        end
        2'b01: begin
          r_instr[0] <= r_instr[1];
          r_pc[0]    <= r_pc[1];
          r_count    <= r_count - 2'd1;
        end
        2'b11: begin
          if (r_count == 2'd1) begin
            r_instr[0] <= imem_rdata;
            r_pc[0]    <= r_pc_inflight;
          end else begin
            r_instr[0] <= r_instr[1];
            r_pc[0]    <= r_pc[1];
            r_instr[1] <= imem_rdata;
            r_pc[1]    <= r_pc_inflight;
          end
        end
        default: begin
          r_count <= r_count;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: reactive memory model, expected-PC scoreboard refilled
// on every reset/redirect, and a negedge monitor checking requests and deliveries.
module tb_instr_fetch_unit;

  localparam logic [7:0] RST_PC = 8'h10;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [15:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [2:0]  opCode;
  logic [7:0]  instr_pc;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_pops   = 0;
  int          n_acc    = 0;
  int          lat_min  = 0;
  int          lat_max  = 0;
  int          gnt_pct  = 100;
  bit          mem_pend = 1'b0;
  logic [7:0]  mem_addr;
  int          mem_cnt;
  logic [7:0]  exp_q [$];
  logic [7:0]  req_next;
  logic [7:0]  mon_pc;
  logic [15:0] mon_w;

  instr_fetch_unit #(.INSTR_W(16), .ADDR_W(8), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .opCode(opCode), .instr_pc(instr_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  // Contents of instruction memory: 0x2000+a for a < 0x20, varied opcode above.
  function automatic logic [15:0] mem_word(input logic [7:0] a);
    return {a[7:5] ^ 3'b001, 5'b00000, a};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic refill(input logic [7:0] start);
    exp_q.delete();
    for (int i = 0; i < 1024; i++) exp_q.push_back(start + 8'(i));
  endtask

  task automatic do_reset(input int cycles);
    @(posedge clk); #1;
    rst = 1'b1;
    refill(RST_PC);
    repeat (cycles) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic do_redirect(input logic [7:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    refill(pc);
    @(posedge clk); #1;
    redirect_valid = 1'b0;
  endtask

  task automatic wait_accept(input logic [7:0] a, input int budget);
    bit found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if (imem_req && imem_gnt && imem_addr == a) found = 1'b1;
    end
    check($sformatf("accept_of_0x%0h", a), 32'(found), 32'd1);
  endtask

  // Instruction memory: one outstanding read, gnt withheld while busy.
  initial begin
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 16'h0000;
    forever begin
      @(negedge clk);
      if (imem_req && imem_gnt) begin
        mem_pend = 1'b1;
        mem_addr = imem_addr;
        mem_cnt  = $urandom_range(lat_max, lat_min);
      end
      @(posedge clk); #1;
      if (mem_pend) begin
        imem_gnt = 1'b0;
        if (mem_cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_word(mem_addr);
          mem_pend    = 1'b0;
        end else begin
          imem_rvalid = 1'b0;
          mem_cnt--;
        end
      end else begin
        imem_rvalid = 1'b0;
        imem_gnt    = ($urandom_range(99, 0) < gnt_pct);
      end
    end
  end

  // Monitor: request addresses follow the expected fetch stream; pops follow the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        req_next = RST_PC;
      end else begin
        if (imem_req && imem_gnt) begin
          n_acc++;
          check("req_addr", 32'(imem_addr), 32'(req_next));
          req_next = redirect_valid ? redirect_pc : req_next + 8'd1;
        end else if (redirect_valid) begin
          req_next = redirect_pc;
        end
        if (instr_valid && instr_ready && !redirect_valid) begin
          n_pops++;
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_empty: got pc 0x%0h, expected no delivery", instr_pc);
          end else begin
            mon_pc = exp_q.pop_front();
            mon_w  = mem_word(mon_pc);
            check("instr_pc", 32'(instr_pc), 32'(mon_pc));
            check("instr", 32'(instr), 32'(mon_w));
            check("opCode", 32'(opCode), 32'(mon_w[15:13]));
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc_base;
    int rst_hold;
    bit found;
    instr_ready    = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 8'h00;
    refill(RST_PC);
    #1 rst = 1'b1;
    #1;
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_addr", 32'(imem_addr), 32'(RST_PC));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Zero-wait stream: request every other cycle, delivery two cycles after accept.
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("stream_req", 32'(imem_req), 32'(k % 2 == 0));
      if (k % 2 == 0) check("stream_addr", 32'(imem_addr), 32'(8'h10 + 8'(k / 2)));
      check("stream_valid", 32'(instr_valid), 32'(k >= 2 && k % 2 == 0));
      if (k >= 2 && k % 2 == 0) check("stream_pc", 32'(instr_pc), 32'(8'h10 + 8'(k / 2) - 8'h01));
    end
    repeat (10) @(negedge clk);

    // Backpressure from reset: two entries fill, then requests stop.
    @(posedge clk); #1 instr_ready = 1'b0;
    do_reset(2);
    acc_base = n_acc;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k >= 4) begin
        check("bp_req", 32'(imem_req), 32'd0);
        check("bp_head_pc", 32'(instr_pc), 32'h10);
      end
    end
    check("bp_accepts", 32'(n_acc - acc_base), 32'd2);
    check("bp_head_instr", 32'(instr), 32'h2010);
    check("bp_next_addr", 32'(imem_addr), 32'h12);
    @(posedge clk); #1;
    instr_ready = 1'b1;
    lat_min = 2;
    lat_max = 2;
    wait_accept(8'h12, 10);

    // Redirect while waiting on 0x13, with 0x12 still buffered.
    @(posedge clk); #1 instr_ready = 1'b0;
    wait_accept(8'h13, 20);
    @(posedge clk); #1;
    redirect_valid = 1'b1;
    redirect_pc    = 8'h40;
    refill(8'h40);
    @(negedge clk);
    check("rdw_pre_valid", 32'(instr_valid), 32'd1);
    check("rdw_pre_pc", 32'(instr_pc), 32'h12);
    @(posedge clk); #1 redirect_valid = 1'b0;
    @(negedge clk);
    check("rdw_flushed", 32'(instr_valid), 32'd0);
    check("rdw_drop_req", 32'(imem_req), 32'd0);
    check("rdw_addr", 32'(imem_addr), 32'h40);
    @(posedge clk); #1;
    instr_ready = 1'b1;
    lat_min = 0;
    lat_max = 0;
    wait_accept(8'h40, 20);
    repeat (6) @(negedge clk);

    // Redirect in the same cycle as a response.
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk); #3;
      if (imem_rvalid) begin
        found = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 8'h80;
        refill(8'h80);
      end
    end
    check("rdv_found", 32'(found), 32'd1);
    @(posedge clk); #1 redirect_valid = 1'b0;
    @(negedge clk);
    check("rdv_req", 32'(imem_req), 32'd1);
    check("rdv_addr", 32'(imem_addr), 32'h80);
    repeat (6) @(negedge clk);

    // Redirect in the same cycle as an accept.
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk); #3;
      if (imem_req && imem_gnt) begin
        found = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 8'hC0;
        refill(8'hC0);
      end
    end
    check("rda_found", 32'(found), 32'd1);
    @(posedge clk); #1 redirect_valid = 1'b0;
    @(negedge clk);
    check("rda_req", 32'(imem_req), 32'd0);
    check("rda_addr", 32'(imem_addr), 32'hC0);
    check("rda_valid", 32'(instr_valid), 32'd0);
    wait_accept(8'hC0, 10);
    repeat (6) @(negedge clk);

    // Address wrap.
    @(posedge clk); #1;
    do_redirect(8'hFE);
    wait_accept(8'hFE, 12);
    wait_accept(8'hFF, 12);
    wait_accept(8'h00, 12);
    repeat (8) @(negedge clk);

    // Asynchronous reset while a response is outstanding.
    @(posedge clk); #1;
    instr_ready = 1'b0;
    lat_min = 6;
    lat_max = 6;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(posedge clk); #3;
      if (instr_valid && mem_pend && !imem_req) found = 1'b1;
    end
    check("ar_found_wait", 32'(found), 32'd1);
    rst = 1'b1;
    refill(RST_PC);
    #1;
    check("ar_req", 32'(imem_req), 32'd0);
    check("ar_valid", 32'(instr_valid), 32'd0);
    check("ar_addr", 32'(imem_addr), 32'(RST_PC));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    instr_ready = 1'b1;
    lat_min = 0;
    lat_max = 0;
    wait_accept(RST_PC, 20);
    repeat (8) @(negedge clk);

    // Random traffic: latency, grant, ready, redirects and resets.
    lat_min  = 0;
    lat_max  = 3;
    gnt_pct  = 70;
    rst_hold = 0;
    acc_base = n_pops;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      redirect_valid = 1'b0;
      instr_ready    = ($urandom_range(99, 0) < 70);
      if (rst_hold > 0) begin
        rst_hold--;
        if (rst_hold == 0) rst = 1'b0;
      end else if ($urandom_range(399, 0) == 0) begin
        rst = 1'b1;
        refill(RST_PC);
        rst_hold = 2;
      end else if ($urandom_range(29, 0) == 0) begin
        redirect_valid = 1'b1;
        redirect_pc    = 8'($urandom);
        refill(redirect_pc);
      end
    end
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    rst            = 1'b0;
    instr_ready    = 1'b1;
    repeat (30) @(posedge clk);
    check("random_progress", 32'(n_pops - acc_base > 100), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
